guitar_game_ctrl: RTL and testbench
===================================

// Module: guitar_game_ctrl
// PURPOSE
//  Registered game sequencer for the guitar-hero VGA design. Owns the game state (TITLE/PLAY/GAMEOVER),
//  the saturating score, the note-speed value fed to the lane blocks, and a note-spawn scheduler that
//  issues spawn requests to the four lane blocks over a req/ack handshake.
//  Sits between the lane/block modules (flags in) and the VGA bitchange colour mux (state and score out).
// PARAMETERS
//  SCORE_W        16      score width
//  SPEED_W        50      speed_shift width
//  SPEED_STEP     1000    speed increment per point
//  SPEED_CAP      100     score at/above which speed_shift = SPEED_MAX
//  SPEED_MAX      200000  capped speed value
//  SPAWN_DIV      60      frame_ticks between spawn events (>=1)
//  LFSR_SEED      8'hA5   spawn LFSR reset value (nonzero)
// PORTS
//  clk          in   1        system clock
//  resetbtn     in   1        synchronous active-high reset
//  start_sw     in   1        start switch level (already synchronised)
//  frame_tick   in   1        1-cycle pulse per video frame
//  point_pulse  in   4        per-lane hit pulses {red,blue,yellow,pink}
//  lane_gone    in   4        per-lane block-gone levels, same order
//  miss_over    in   1        lane logic requests game over (level)
//  spawn_ack    in   4        lane accepted spawn, 1-cycle pulse
//  gamestate    out  2        01 TITLE, 10 PLAY, 11 GAMEOVER
//  score        out  SCORE_W  current score
//  speed_shift  out  SPEED_W  note speed value
//  spawn_req    out  4        one-hot spawn request, held until ack
// BEHAVIOUR
//  - Reset: gamestate=TITLE, score=0, speed_shift=0, spawn_req=0, frame counter=0, LFSR=LFSR_SEED, start_sw edge reg=0.
//  - Reset mid-game aborts everything in one cycle; no outputs keep stale values.
//  - FSM (registered, 1-cycle latency):
//    TITLE->PLAY on start_sw rising edge (sampled vs previous cycle); score cleared on this transition.
//    PLAY->GAMEOVER when miss_over=1 or lane_gone==4'hF; same-cycle point pulses still count.
//    GAMEOVER->TITLE when start_sw==0. Encoding 2'b00 is unreachable; it recovers to TITLE next cycle.
//  - Score: PLAY only; score += popcount(point_pulse) each cycle (0..4), saturates at 2^SCORE_W-1, never wraps.
//    Held in TITLE/GAMEOVER.
//  - speed_shift: registered from score, 1-cycle lag:
//    score<SPEED_CAP ? score*SPEED_STEP : SPEED_MAX.
//  - Spawn: frame counter runs in PLAY only, counts frame_tick 0..SPAWN_DIV-1 and wraps.
//    Wrap = spawn event. Each event steps the LFSR (x^8+x^6+x^5+x^4+1) once.
//    Candidate lane = lfsr[1:0]; if that lane is gone, rotate upward mod 4 to the first non-gone lane.
//    All lanes gone -> no request.
//    Event accepted only if spawn_req==0 at that cycle, otherwise dropped (LFSR still steps).
//    spawn_req bit is cleared the cycle after the matching spawn_ack. An ack on a non-requested lane is ignored.
//    An ack and a new event in the same cycle: the event is dropped.
//  - Leaving PLAY clears spawn_req and the frame counter; the LFSR is kept.
// CONFIGURATION
//  HIGH_SCORE_EN defined: extra output high_score [SCORE_W] (reset 0).
//    Loaded with score on the PLAY->GAMEOVER transition if score>high_score (uses the final score incl. same-cycle pulses).
//    Cleared only by resetbtn.
//  Undefined: port and register absent; all other behaviour identical.
// STRUCTURE
//  guitar_pkg: state encodings (TITLESCREEN/STARTGAME/GAMEOVER), lane index constants, LANES=4.
//  Sub-module lane_spawn_sched: frame counter, LFSR, lane pick, req/ack holding. Top keeps FSM, score, speed.
// TESTING
//  1 reset, start_sw 0->1 -> gamestate 01 then 10 one cycle after edge; score=0; speed_shift=0.
//  2 PLAY, point_pulse=4'b1111 for 3 cycles -> score=12, speed_shift=12000 one cycle later.
//    Force score to 99, then pulse 1 lane -> speed_shift=200000.
//  3 score=16'hFFFE, point_pulse=4'b0011 -> score=16'hFFFF, stays there on further pulses.
//  4 SPAWN_DIV=2, all lanes present, no ack -> exactly one spawn_req bit set, held across later events.
//    Ack -> cleared the next cycle. lane_gone=4'b0111 -> only lane 3 is ever requested.
//  5 PLAY, lane_gone=4'hF -> GAMEOVER next cycle, spawn_req=0, score frozen. start_sw=0 -> TITLE.
//    With HIGH_SCORE_EN: high_score=final score; a lower second game leaves it unchanged.
//  6 resetbtn asserted mid-PLAY with spawn_req pending -> next cycle all reset values, LFSR=8'hA5.

Source files
------------

// File: rtl/guitar_pkg.sv
// Shared definitions for the guitar-hero game controller: state encodings,
// lane indices and small combinational helpers for lane selection and scoring.
package guitar_pkg;

    localparam int LANES       = 4;
    localparam int LANE_PINK   = 0;
    localparam int LANE_YELLOW = 1;
    localparam int LANE_BLUE   = 2;
    localparam int LANE_RED    = 3;

    typedef enum logic [1:0] {
        ST_INVALID  = 2'b00,
        TITLESCREEN = 2'b01,
        STARTGAME   = 2'b10,
        GAMEOVER    = 2'b11
    } game_state_t;

    function automatic logic [2:0] popcount4(input logic [LANES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Starting at the candidate, rotate upward to the first lane still present.
    function automatic logic [LANES-1:0] pick_lane(input logic [1:0] cand,
                                                  input logic [LANES-1:0] gone);
        logic [LANES-1:0] sel;
        logic [1:0]       idx;
        logic             found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            idx = cand + 2'(k);
            if (!found && !gone[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/lane_spawn_sched.sv
// Note-spawn scheduler: divides frame ticks into spawn events, picks a lane with an
// 8-bit LFSR and holds a one-hot request to the lane blocks until it is acknowledged.
module lane_spawn_sched
    import guitar_pkg::*;
#(
    parameter int         SPAWN_DIV = 60,
    parameter logic [7:0] LFSR_SEED = 8'hA5
)
(
    input  logic             clk,
    input  logic             resetbtn,
    input  logic             active,
    input  logic             clear,
    input  logic             frame_tick,
    input  logic [LANES-1:0] lane_gone,
    input  logic [LANES-1:0] spawn_ack,
    output logic [LANES-1:0] spawn_req
);

    localparam int               CNT_W    = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_DIV - 1);

    logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
    logic [7:0]       lfsr, lfsr_nxt;
    logic [LANES-1:0] req_nxt;
    logic             spawn_evt;

    // The lane candidate comes from the LFSR value held when the event fires;
    // the LFSR steps on every event, including ones dropped because a request is pending.
    always_comb begin
        spawn_evt     = active && frame_tick && (frame_cnt == CNT_LAST);
        frame_cnt_nxt = frame_cnt;
        lfsr_nxt      = lfsr;
        req_nxt       = spawn_req & ~spawn_ack;

        if (clear) begin
            frame_cnt_nxt = '0;
        end else if (active && frame_tick) begin
            frame_cnt_nxt = spawn_evt ? '0 : frame_cnt + CNT_W'(1);
        end

        if (spawn_evt) begin
            lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end

        if (clear) begin
            req_nxt = '0;
        end else if (spawn_evt && (spawn_req == '0)) begin
            req_nxt = pick_lane(lfsr[1:0], lane_gone);
        end
    end

    always_ff @(posedge clk) begin
        if (resetbtn) begin
            frame_cnt <= '0;
            lfsr      <= LFSR_SEED;
            spawn_req <= '0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            lfsr      <= lfsr_nxt;
            spawn_req <= req_nxt;
        end
    end

endmodule

// File: rtl/guitar_game_ctrl.sv
// Game sequencer: TITLE/PLAY/GAMEOVER state, saturating score, note speed and spawn scheduling.
// Define HIGH_SCORE_EN to add the high_score output register.
module guitar_game_ctrl
    import guitar_pkg::*;
#(
    parameter int         SCORE_W    = 16,
    parameter int         SPEED_W    = 50,
    parameter int         SPEED_STEP = 1000,
    parameter int         SPEED_CAP  = 100,
    parameter int         SPEED_MAX  = 200000,
    parameter int         SPAWN_DIV  = 60,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
)
(
    input  logic               clk,
    input  logic               resetbtn,
    input  logic               start_sw,
    input  logic               frame_tick,
    input  logic [LANES-1:0]   point_pulse,
    input  logic [LANES-1:0]   lane_gone,
    input  logic               miss_over,
    input  logic [LANES-1:0]   spawn_ack,
    output logic [1:0]         gamestate,
    output logic [SCORE_W-1:0] score,
    output logic [SPEED_W-1:0] speed_shift,
    output logic [LANES-1:0]   spawn_req
`ifdef HIGH_SCORE_EN
   ,output logic [SCORE_W-1:0] high_score
`endif
);

    localparam logic [SCORE_W-1:0] CAP_SCORE = SCORE_W'(SPEED_CAP);

    game_state_t        state, state_nxt;
    logic               start_q;
    logic               start_rise;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [SPEED_W-1:0] speed_nxt;

    assign start_rise = start_sw && !start_q;
    assign gamestate  = state;

    always_ff @(posedge clk) begin
        if (resetbtn) begin
            state <= TITLESCREEN;
        end else begin
            state <= state_nxt;
        end
    end

    // The unused 2'b00 encoding falls through to the default and recovers to TITLE.
    always_comb begin
        state_nxt = state;
        case (state)
            TITLESCREEN: if (start_rise) state_nxt = STARTGAME;
            STARTGAME:   if (miss_over || (lane_gone == '1)) state_nxt = GAMEOVER;
            GAMEOVER:    if (!start_sw) state_nxt = TITLESCREEN;
            default:     state_nxt = TITLESCREEN;
        endcase
    end

    // Hits still count on the cycle that ends the game; the extra sum bit flags overflow.
    always_comb begin
        score_sum = {1'b0, score} + (SCORE_W+1)'(popcount4(point_pulse));
        score_nxt = score;
        if ((state == TITLESCREEN) && (state_nxt == STARTGAME)) begin
            score_nxt = '0;
        end else if (state == STARTGAME) begin
            score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
        speed_nxt = (score < CAP_SCORE) ? SPEED_W'(score) * SPEED_W'(SPEED_STEP)
                                        : SPEED_W'(SPEED_MAX);
    end

    always_ff @(posedge clk) begin
        if (resetbtn) begin
            start_q     <= 1'b0;
            score       <= '0;
            speed_shift <= '0;
        end else begin
            start_q     <= start_sw;
            score       <= score_nxt;
            speed_shift <= speed_nxt;
        end
    end

`ifdef HIGH_SCORE_EN
    always_ff @(posedge clk) begin
        if (resetbtn) begin
            high_score <= '0;
        end else if ((state == STARTGAME) && (state_nxt == GAMEOVER) && (score_nxt > high_score)) begin
            high_score <= score_nxt;
        end
    end
`endif

    lane_spawn_sched #(
        .SPAWN_DIV (SPAWN_DIV),
        .LFSR_SEED (LFSR_SEED)
    ) u_spawn (
        .clk        (clk),
        .resetbtn   (resetbtn),
        .active     (state == STARTGAME),
        .clear      (state_nxt != STARTGAME),
        .frame_tick (frame_tick),
        .lane_gone  (lane_gone),
        .spawn_ack  (spawn_ack),
        .spawn_req  (spawn_req)
    );

endmodule

// File: tb/tb_guitar_game_ctrl.sv
// Directed testbench for guitar_game_ctrl built with SPAWN_DIV=2; expected values are hand-derived.
// Define HIGH_SCORE_EN to also exercise the high_score register.
module tb_guitar_game_ctrl;

    logic        clk = 1'b0;
    logic        resetbtn;
    logic        start_sw;
    logic        frame_tick;
    logic [3:0]  point_pulse;
    logic [3:0]  lane_gone;
    logic        miss_over;
    logic [3:0]  spawn_ack;
    logic [1:0]  gamestate;
    logic [15:0] score;
    logic [49:0] speed_shift;
    logic [3:0]  spawn_req;
`ifdef HIGH_SCORE_EN
    logic [15:0] high_score;
`endif

    int nvec  = 0;
    int nmiss = 0;

    always #5 clk = ~clk;

    guitar_game_ctrl #(.SPAWN_DIV(2)) dut (
        .clk         (clk),
        .resetbtn    (resetbtn),
        .start_sw    (start_sw),
        .frame_tick  (frame_tick),
        .point_pulse (point_pulse),
        .lane_gone   (lane_gone),
        .miss_over   (miss_over),
        .spawn_ack   (spawn_ack),
        .gamestate   (gamestate),
        .score       (score),
        .speed_shift (speed_shift),
        .spawn_req   (spawn_req)
`ifdef HIGH_SCORE_EN
       ,.high_score  (high_score)
`endif
    );

    typedef struct {
        logic        start;
        logic [3:0]  pp;
        logic [3:0]  gone;
        logic        miss;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [49:0] sp;
    } vec_t;

    vec_t tbl [15];

    task automatic applyStimulus(input logic st, input logic ft, input logic [3:0] pp,
                                 input logic [3:0] gone, input logic miss, input logic [3:0] ack);
        start_sw    = st;
        frame_tick  = ft;
        point_pulse = pp;
        lane_gone   = gone;
        miss_over   = miss;
        spawn_ack   = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string what, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] st, input logic [15:0] sc,
                            input logic [49:0] sp, input logic [3:0] rq);
        checkOutput({tag, " gamestate"},   64'(gamestate),   64'(st));
        checkOutput({tag, " score"},       64'(score),       64'(sc));
        checkOutput({tag, " speed_shift"}, 64'(speed_shift), 64'(sp));
        checkOutput({tag, " spawn_req"},   64'(spawn_req),   64'(rq));
    endtask

    task automatic tick(input logic [3:0] gone, input logic [3:0] ack);
        applyStimulus(1'b1, 1'b1, 4'h0, gone, 1'b0, ack);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'b01, 16'd0,  50'd0};
        tbl[1]  = '{1'b1, 4'h0, 4'h0, 1'b0, 2'b10, 16'd0,  50'd0};
        tbl[2]  = '{1'b1, 4'hF, 4'h0, 1'b0, 2'b10, 16'd4,  50'd0};
        tbl[3]  = '{1'b1, 4'hF, 4'h0, 1'b0, 2'b10, 16'd8,  50'd4000};
        tbl[4]  = '{1'b1, 4'hF, 4'h0, 1'b0, 2'b10, 16'd12, 50'd8000};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 1'b0, 2'b10, 16'd12, 50'd12000};
        tbl[6]  = '{1'b1, 4'h5, 4'h0, 1'b0, 2'b10, 16'd14, 50'd12000};
        tbl[7]  = '{1'b1, 4'h8, 4'h0, 1'b0, 2'b10, 16'd15, 50'd14000};
        tbl[8]  = '{1'b1, 4'h0, 4'h7, 1'b0, 2'b10, 16'd15, 50'd15000};
        tbl[9]  = '{1'b1, 4'h2, 4'h0, 1'b1, 2'b11, 16'd16, 50'd15000};
        tbl[10] = '{1'b1, 4'hF, 4'h0, 1'b0, 2'b11, 16'd16, 50'd16000};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 2'b01, 16'd16, 50'd16000};
        tbl[12] = '{1'b0, 4'hF, 4'h0, 1'b0, 2'b01, 16'd16, 50'd16000};
        tbl[13] = '{1'b1, 4'h0, 4'h0, 1'b0, 2'b10, 16'd0,  50'd16000};
        tbl[14] = '{1'b1, 4'h0, 4'h0, 1'b0, 2'b10, 16'd0,  50'd0};

        resetbtn = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        checkAll("reset", 2'b01, 16'd0, 50'd0, 4'h0);
        resetbtn = 1'b0;

        // State walk, scoring and speed lag.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].start, 1'b0, tbl[i].pp, tbl[i].gone, tbl[i].miss, 4'h0);
            checkAll($sformatf("row%0d", i), tbl[i].st, tbl[i].sc, tbl[i].sp, 4'h0);
        end
`ifdef HIGH_SCORE_EN
        checkOutput("high_score first game", 64'(high_score), 64'd16);
`endif

        // Speed cap boundary: 99 -> 99000, 100 -> SPEED_MAX.
        repeat (24) applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h7, 4'h0, 1'b0, 4'h0);
        checkOutput("score 99", 64'(score), 64'd99);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        checkOutput("speed at 99", 64'(speed_shift), 64'd99000);
        applyStimulus(1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        checkAll("cap", 2'b10, 16'd100, 50'd200000, 4'h0);

        // Spawn events: LFSR A5 -> 4A -> 95 -> 2A -> 54 -> A9 -> 53 -> A7.
        tick(4'h0, 4'h0);
        checkOutput("req before event", 64'(spawn_req), 64'h0);
        tick(4'h0, 4'h0);
        checkOutput("req event1", 64'(spawn_req), 64'h2);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h0);
        checkOutput("req held over event2", 64'(spawn_req), 64'h2);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h1);
        checkOutput("req foreign ack", 64'(spawn_req), 64'h2);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h2);
        checkOutput("req acked", 64'(spawn_req), 64'h0);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h0);
        checkOutput("req event3", 64'(spawn_req), 64'h2);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h2);
        checkOutput("req ack with event4", 64'(spawn_req), 64'h0);
        tick(4'h7, 4'h0);
        tick(4'h7, 4'h0);
        checkOutput("req event5 rotate", 64'(spawn_req), 64'h8);
        tick(4'h7, 4'h0);
        tick(4'h7, 4'h0);
        checkOutput("req held over event6", 64'(spawn_req), 64'h8);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h7, 1'b0, 4'h8);
        checkOutput("req lane3 acked", 64'(spawn_req), 64'h0);
        tick(4'h7, 4'h0);
        tick(4'h7, 4'h0);
        checkOutput("req event7", 64'(spawn_req), 64'h8);

        // All lanes gone ends the game; the same-cycle hit still counts.
        applyStimulus(1'b1, 1'b0, 4'h1, 4'hF, 1'b0, 4'h0);
        checkOutput("gameover state", 64'(gamestate), 64'h3);
        checkOutput("gameover score", 64'(score), 64'd101);
        checkOutput("gameover req", 64'(spawn_req), 64'h0);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0);
        checkAll("frozen", 2'b11, 16'd101, 50'd200000, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        checkOutput("back to title", 64'(gamestate), 64'h1);
`ifdef HIGH_SCORE_EN
        checkOutput("high_score second game", 64'(high_score), 64'd101);
`endif

        // Lower-scoring game.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 4'h0);
        checkOutput("short game state", 64'(gamestate), 64'h3);
        checkOutput("short game score", 64'(score), 64'd2);
`ifdef HIGH_SCORE_EN
        checkOutput("high_score kept", 64'(high_score), 64'd101);
`endif
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h0);
        checkOutput("req event8", 64'(spawn_req), 64'h8);
        applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 4'h0);

        // Reset mid-game with a request pending.
        resetbtn = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        checkAll("midreset", 2'b01, 16'd0, 50'd0, 4'h0);
`ifdef HIGH_SCORE_EN
        checkOutput("high_score reset", 64'(high_score), 64'd0);
`endif
        resetbtn = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        checkOutput("replay state", 64'(gamestate), 64'h2);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h0);
        checkOutput("req after reseed", 64'(spawn_req), 64'h2);

        // Score saturation.
        repeat (16383) applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 4'h0);
        checkOutput("score FFFE", 64'(score), 64'hFFFE);
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 4'h0);
        checkOutput("score FFFF", 64'(score), 64'hFFFF);
        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0);
        checkOutput("score held FFFF", 64'(score), 64'hFFFF);
        checkOutput("speed saturated", 64'(speed_shift), 64'd200000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
